bin_to_bcd_loader: RTL and testbench
====================================

# bin_to_bcd_loader

Sequential binary-to-BCD converter that produces preset digits for the cascaded BCD digit counters in the VGA score/timer path. It takes a binary value (score, time limit), converts it with shift-and-add-3 (double-dabble) at one bit per clock, and presents packed BCD digits with a one-cycle active-low load strobe. Those outputs drive the counters' `datain`/`loadN` inputs directly. It is the writer side of the counter preset interface; the counters are the reader.

## Interface
- `BIN_WIDTH`, default 14: width of the binary input. Maximum value is 2^BIN_WIDTH-1.
- `DIGITS`, default 4: number of BCD digits produced.
- `clk` input 1: system clock. All logic is on its rising edge.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `start` input 1: conversion request. Sampled only in IDLE.
- `bin_in` input BIN_WIDTH: value to convert. Captured on the accepted `start` edge.
- `busy` output 1: high while a conversion is in progress (SHIFT and DONE states).
- `done` output 1: one-cycle pulse when `bcd_out` holds the new result.
- `loadN` output 1: active-low load strobe. It is the exact complement of `done`.
- `bcd_out` output 4*DIGITS: packed BCD. Digit 0 (units) is in bits [3:0].
- `overflow` output 1: captured `bin_in` exceeded 10^DIGITS-1. Valid with `done`; held until the next `done`.

## Operation
- States:
  - IDLE: `busy`=0. On `start`=1, capture `bin_in` into a shift register, clear the BCD scratch register, load bit counter = BIN_WIDTH, evaluate the overflow compare, and go to SHIFT.
  - SHIFT: each cycle, first add 3 to every scratch digit ≥5, then shift {scratch, bin} left by one and decrement the counter. When the counter reaches 0 (after BIN_WIDTH shifts), go to DONE.
  - DONE: register the result into `bcd_out`, drive `done`=1 and `loadN`=0 for this one cycle, then go to IDLE.
- `start` in SHIFT or DONE is ignored. It is not queued.
- `bcd_out` and `overflow` hold their value between `done` pulses. The scratch register is never visible on the outputs.
- Digits are always valid BCD (0-9). The add-3 logic works per digit on 4 bits, and the carry out of the top digit is discarded.
- Overflow compare: `bin_in` > 10^DIGITS-1, evaluated at full BIN_WIDTH in the IDLE capture cycle.
- Reset in any state: go to IDLE, `bcd_out`=0, `overflow`=0, `busy`=0, `done`=0, `loadN`=1. An interrupted conversion produces no strobe.
- `start` together with `reset`: reset wins.

## Timing
- Reset values: `busy`=0, `done`=0, `loadN`=1, `bcd_out`=0, `overflow`=0.
- `start` sampled high at edge E0 (in IDLE):
  - `busy`=1 after E0.
  - Shifts occur on edges E1 through E_BIN_WIDTH.
  - After edge E(BIN_WIDTH+1), `done`=1, `loadN`=0 and `bcd_out` is valid.
  - After edge E(BIN_WIDTH+2), `done`=0, `loadN`=1 and `busy`=0.
- Latency from `start` to `done`: BIN_WIDTH+1 cycles. With defaults, `done` is high in cycle 15 after `start`.
- Minimum request spacing: BIN_WIDTH+2 cycles. The next `start` can be accepted in the first IDLE cycle after DONE.
- No combinational path from inputs to outputs. All outputs are registered.

## Configuration
- Macro `BCD_SATURATE_EN`.
- Defined: when `overflow` is set, `bcd_out` is forced to all digits 9 (0x9999 with defaults).
- Not defined: `bcd_out` is the natural truncated result, `bin_in` mod 10^DIGITS. `overflow` is still flagged.
- `overflow` behaviour and all timing are identical in both builds.

## Test plan
- After reset, no `start` -> `busy`=0, `done`=0, `loadN`=1, `bcd_out`=0x0000, `overflow`=0 for 20 cycles.
- `bin_in`=1234, `start` pulse -> in cycle 15 `done`=1, `loadN`=0, `bcd_out`=0x1234, `overflow`=0. Next cycle `busy`=0. Output holds 0x1234 afterwards.
- Boundary values:
  - `bin_in`=0 -> `bcd_out`=0x0000.
  - `bin_in`=9999 -> `bcd_out`=0x9999, `overflow`=0.
  - `bin_in`=10 -> `bcd_out`=0x0010.
- `bin_in`=16383:
  - With `BCD_SATURATE_EN` -> `bcd_out`=0x9999, `overflow`=1.
  - Without it -> `bcd_out`=0x6383, `overflow`=1.
- Start while busy: `start` with 42, then `start` with 777 in cycle 5 -> exactly one `done`, in cycle 15, with `bcd_out`=0x0042. A following `start` with 777 in IDLE -> 0x0777.
- Reset mid-conversion: `reset` in cycle 8 -> no `done`/`loadN` strobe, `bcd_out`=0x0000, `busy`=0. A new `start` with 5 -> `bcd_out`=0x0005 after 15 cycles.

Source files
------------

// File: rtl/bin_to_bcd_loader.sv
// Sequential double-dabble binary-to-BCD converter that presets cascaded BCD counters via datain/loadN.
// Optional build macro BCD_SATURATE_EN: out-of-range inputs present all-9 digits instead of the truncated value.
module bin_to_bcd_loader #(
   parameter int BIN_WIDTH = 14,
   parameter int DIGITS    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_WIDTH-1:0]  bin_in,
   output logic                  busy,
   output logic                  done,
   output logic                  loadN,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow,
   output logic [1:0]            dbg_state
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   function automatic logic [63:0] dec_max_f();
      logic [63:0] m;
      m = 64'd1;
      for (int d = 0; d < DIGITS; d++) begin
         m = m * 64'd10;
      end
      return m - 64'd1;
   endfunction

   localparam logic [63:0] DEC_MAX = dec_max_f();

   // Per-digit correction; the carry out of the top digit is dropped by the later shift.
   function automatic logic [BCD_W-1:0] add3_f(input logic [BCD_W-1:0] s);
      logic [BCD_W-1:0] r;
      r = s;
      for (int d = 0; d < DIGITS; d++) begin
         if (s[4*d +: 4] >= 4'd5) begin
            r[4*d +: 4] = s[4*d +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [BIN_WIDTH-1:0] r_bin;
   logic [BCD_W-1:0]     r_scratch;
   logic [CNT_W-1:0]     r_cnt;
   logic [BCD_W-1:0]     r_bcd;
   logic                 r_overflow;
   logic                 r_ovf_pend;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_load_n;
   logic [BCD_W-1:0]     w_adj;
   logic [BCD_W-1:0]     w_result;
   logic                 w_ovf;

   assign w_adj = add3_f(r_scratch);
   assign w_ovf = (64'(bin_in) > DEC_MAX);

`ifdef BCD_SATURATE_EN
   assign w_result = r_ovf_pend ? {DIGITS{4'h9}} : r_scratch;
`else
   assign w_result = r_scratch;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_SHIFT;
         S_SHIFT: if (r_cnt == CNT_LAST) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // busy covers the strobe cycle too, so it is registered one step behind the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin      <= '0;
         r_scratch  <= '0;
         r_cnt      <= '0;
         r_bcd      <= '0;
         r_overflow <= 1'b0;
         r_ovf_pend <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_load_n   <= 1'b1;
      end else begin
         r_done   <= 1'b0;
         r_load_n <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_busy <= start;
               if (start) begin
                  r_bin      <= bin_in;
                  r_scratch  <= '0;
                  r_cnt      <= CNT_INIT;
                  r_ovf_pend <= w_ovf;
               end
            end
            S_SHIFT: begin
               r_busy               <= 1'b1;
               {r_scratch, r_bin}   <= {w_adj, r_bin} << 1;
               r_cnt                <= r_cnt - CNT_LAST;
            end
            S_DONE: begin
               r_busy     <= 1'b1;
               r_bcd      <= w_result;
               r_overflow <= r_ovf_pend;
               r_done     <= 1'b1;
               r_load_n   <= 1'b0;
            end
            default: r_busy <= 1'b0;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign loadN     = r_load_n;
   assign bcd_out   = r_bcd;
   assign overflow  = r_overflow;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_bin_to_bcd_loader.sv
// Directed bench for bin_to_bcd_loader: reset state, conversions, boundaries, ignored start, mid-conversion reset.
module tb_bin_to_bcd_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic [13:0] bin_in;
   logic        busy;
   logic        done;
   logic        loadN;
   logic [15:0] bcd_out;
   logic        overflow;
   logic [1:0]  dbg_state;

   int checks;
   int failures;

   int          found;
   int          pulses;
   int          strobe_bad;
   logic [15:0] bcd_at;
   logic        ovf_at;
   logic        loadn_at;
   logic        busy_after;
   logic        busy_first;
   logic [15:0] exp_big;

   bin_to_bcd_loader #(.BIN_WIDTH(14), .DIGITS(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bin_in    (bin_in),
      .busy      (busy),
      .done      (done),
      .loadN     (loadN),
      .bcd_out   (bcd_out),
      .overflow  (overflow),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Loop index i means the observation after posedge E_i, where E0 samples start.
   task automatic run_conv(input logic [13:0] v, input logic [13:0] v2, input int mid_at, input int rst_at);
      found      = -1;
      pulses     = 0;
      strobe_bad = 0;
      bcd_at     = 16'hxxxx;
      ovf_at     = 1'bx;
      loadn_at   = 1'bx;
      busy_after = 1'bx;
      busy_first = 1'bx;
      @(negedge clk);
      start  = 1'b1;
      bin_in = v;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) busy_first = busy;
         if (done) begin
            pulses++;
            if (found < 0) found = i;
            bcd_at   = bcd_out;
            ovf_at   = overflow;
            loadn_at = loadN;
         end
         if (loadN !== ~done) strobe_bad++;
         if (found >= 0 && i == found + 1) busy_after = busy;
         start = 1'b0;
         if (i == mid_at - 1) begin
            start  = 1'b1;
            bin_in = v2;
         end
         reset = (i == rst_at - 1);
      end
   endtask

   task automatic conv_checks(input string tag, input logic [13:0] v,
                              input logic [15:0] exp_bcd, input logic exp_ovf);
      run_conv(v, 14'd0, -10, -10);
      chk({tag, "_busy_e0"}, 32'(busy_first), 32'd1);
      chk({tag, "_latency"}, 32'(found), 32'd15);
      chk({tag, "_pulses"}, 32'(pulses), 32'd1);
      chk({tag, "_bcd"}, 32'(bcd_at), 32'(exp_bcd));
      chk({tag, "_ovf"}, 32'(ovf_at), 32'(exp_ovf));
      chk({tag, "_loadn"}, 32'(loadn_at), 32'd0);
      chk({tag, "_busy_after"}, 32'(busy_after), 32'd0);
      chk({tag, "_strobe_pair"}, 32'(strobe_bad), 32'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      start    = 1'b0;
      bin_in   = 14'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("reset_state", {26'd0, busy, done, loadN, overflow, dbg_state}, {26'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
         chk("reset_bcd", 32'(bcd_out), 32'h0);
      end

      conv_checks("v1234", 14'd1234, 16'h1234, 1'b0);
      repeat (5) @(negedge clk);
      chk("hold_bcd", 32'(bcd_out), 32'h1234);
      chk("hold_done", {30'd0, done, loadN}, {30'd0, 1'b0, 1'b1});

      conv_checks("v0", 14'd0, 16'h0000, 1'b0);
      conv_checks("v9999", 14'd9999, 16'h9999, 1'b0);
      conv_checks("v10", 14'd10, 16'h0010, 1'b0);
`ifdef BCD_SATURATE_EN
      exp_big = 16'h9999;
`else
      exp_big = 16'h6383;
`endif
      conv_checks("v16383", 14'd16383, exp_big, 1'b1);
      repeat (3) @(negedge clk);
      chk("ovf_hold", 32'(overflow), 32'd1);
      conv_checks("v10000", 14'd10000,
`ifdef BCD_SATURATE_EN
                  16'h9999,
`else
                  16'h0000,
`endif
                  1'b1);
      conv_checks("v9", 14'd9, 16'h0009, 1'b0);
      chk("ovf_cleared", 32'(overflow), 32'd0);

      run_conv(14'd42, 14'd777, 5, -10);
      chk("busy_start_latency", 32'(found), 32'd15);
      chk("busy_start_pulses", 32'(pulses), 32'd1);
      chk("busy_start_bcd", 32'(bcd_at), 32'h0042);
      chk("busy_start_idle", 32'(busy), 32'd0);
      conv_checks("v777", 14'd777, 16'h0777, 1'b0);

      run_conv(14'd1234, 14'd0, -10, 8);
      chk("midrst_pulses", 32'(pulses), 32'd0);
      chk("midrst_strobe_pair", 32'(strobe_bad), 32'd0);
      chk("midrst_bcd", 32'(bcd_out), 32'h0000);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_state", 32'(dbg_state), 32'd0);
      conv_checks("v5", 14'd5, 16'h0005, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
